// File: rtl/i2c_pkg.sv
// Shared encodings for the single-byte I2C master: FSM states, R/W codes and
// the quarter-bit indices used to place SCL/SDA edges inside a bit time.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_NACK,
        ST_STOP
    } i2c_state_t;

    localparam logic       I2C_RW_WRITE = 1'b0;
    localparam logic       I2C_RW_READ  = 1'b1;
    localparam logic [6:0] I2C_DEF_ADDR = 7'h66;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_if.sv
// Request/response handshake between on-chip logic and the I2C master.
interface i2c_if;

    logic       i_start;
    logic       i_rw;
    logic [6:0] i_addr;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;
    logic       o_busy;
    logic       o_done;
    logic       o_nack;

    modport master (
        output i_start, i_rw, i_addr, i_wdata,
        input  o_rdata, o_busy, o_done, o_nack
    );

    modport slave (
        input  i_start, i_rw, i_addr, i_wdata,
        output o_rdata, o_busy, o_done, o_nack
    );

endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timebase: CLK_DIV system clocks per quarter, four quarters per bit.
// Held at quarter 0, count 0 while the controller is idle.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    output logic       o_qtick,
    output logic [1:0] o_quarter
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pulse marks the last clock of a quarter; the next edge opens quarter r_q+1.
    assign o_qtick   = !i_clr && (r_cnt == LAST);
    assign o_quarter = r_q;

endmodule

// File: rtl/i2c_master_controller.sv
// Single-master I2C controller: START, address+R/W, ACK, one data byte, STOP.
// SCL/SDA are registered and only change on quarter boundaries.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic  i_clk,
    input  logic  i_rst,
    i2c_if.slave  host,
    output logic  o_scl,
    inout  wire   io_sda
);

    i2c_state_t r_state, w_state_nxt;

    logic       w_qtick, w_bit_end, w_accept, w_clr, w_sda_in;
    logic [1:0] w_q, w_nq;
    logic       w_scl_nxt, w_sda_low_nxt;

    logic [2:0] r_bit;
    logic [7:0] r_tx, r_rx, r_wd, r_rdata;
    logic       r_rw, r_ack, r_fin;
    logic       r_scl, r_sda_low;
    logic       r_busy, r_done, r_nack;

    assign w_clr = (r_state == ST_IDLE);

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_clr),
        .o_qtick   (w_qtick),
        .o_quarter (w_q)
    );

    assign w_accept  = (r_state == ST_IDLE) && host.i_start && !r_busy;
    assign w_bit_end = w_qtick && (w_q == Q3);
    assign w_nq      = w_q + 2'd1;
    // Anything other than a driven 0 (released, floating, unknown) reads as 1.
    assign w_sda_in  = !(io_sda === 1'b0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_nxt = ST_START;
            ST_START:     if (w_bit_end) w_state_nxt = ST_ADDR;
            ST_ADDR:      if (w_bit_end && r_bit == 3'd7) w_state_nxt = ST_ADDR_ACK;
            ST_ADDR_ACK:  if (w_bit_end) begin
                              if (!r_ack)                   w_state_nxt = ST_STOP;
                              else if (r_rw == I2C_RW_READ) w_state_nxt = ST_READ;
                              else                          w_state_nxt = ST_WRITE;
                          end
            ST_WRITE:     if (w_bit_end && r_bit == 3'd7) w_state_nxt = ST_WRITE_ACK;
            ST_WRITE_ACK: if (w_bit_end) w_state_nxt = ST_STOP;
            ST_READ:      if (w_bit_end && r_bit == 3'd7) w_state_nxt = ST_READ_NACK;
            ST_READ_NACK: if (w_bit_end) w_state_nxt = ST_STOP;
            ST_STOP:      if (w_bit_end) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus levels for the quarter about to open; SDA holds through q0 and moves at q1.
    always_comb begin
        w_scl_nxt     = w_nq[1];
        w_sda_low_nxt = r_sda_low;
        case (w_state_nxt)
            ST_IDLE: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b0;
            end
            ST_START: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = w_nq[1];
            end
            ST_ADDR, ST_WRITE: begin
                if (w_nq != Q0) w_sda_low_nxt = ~r_tx[7];
            end
            ST_STOP: begin
                w_sda_low_nxt = (w_nq != Q3);
            end
            default: begin
                if (w_nq != Q0) w_sda_low_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_wd      <= '0;
            r_rw      <= I2C_RW_WRITE;
            r_ack     <= 1'b0;
            r_fin     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_fin  <= (r_state == ST_STOP) && w_bit_end;
            r_done <= r_fin;

            if (w_qtick) begin
                r_scl     <= w_scl_nxt;
                r_sda_low <= w_sda_low_nxt;
            end

            if (w_accept) begin
                r_busy <= 1'b1;
                r_nack <= 1'b0;
                r_rw   <= host.i_rw;
                r_tx   <= {host.i_addr, host.i_rw};
                r_wd   <= host.i_wdata;
                r_bit  <= '0;
            end else if (r_fin) begin
                r_busy <= 1'b0;
            end

            if (r_fin && r_rw == I2C_RW_READ && !r_nack) r_rdata <= r_rx;

            // Sample at the opening of q3, mid SCL-high.
            if (w_qtick && w_q == Q2) begin
                if (r_state == ST_ADDR_ACK) r_ack <= !w_sda_in;
                if (r_state == ST_READ)     r_rx  <= {r_rx[6:0], w_sda_in};
            end

            if (w_bit_end) begin
                case (r_state)
                    ST_ADDR, ST_WRITE: begin
                        r_bit <= r_bit + 3'd1;
                        r_tx  <= {r_tx[6:0], 1'b0};
                    end
                    ST_READ: r_bit <= r_bit + 3'd1;
                    ST_ADDR_ACK: begin
                        if (!r_ack) r_nack <= 1'b1;
                        else        r_tx   <= r_wd;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_scl        = r_scl;
    assign io_sda       = r_sda_low ? 1'b0 : 1'bz;
    assign host.o_busy  = r_busy;
    assign host.o_done  = r_done;
    assign host.o_nack  = r_nack;
    assign host.o_rdata = r_rdata;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: oversampling bus monitor + slave at 7'h66,
// table-driven directed transactions, hand sequences and random traffic vs a model.
module tb_i2c_master_controller;
    import i2c_pkg::*;

    localparam int         CD       = 4;
    localparam logic [7:0] SLV_BYTE = 8'hAD;

    logic i_clk = 1'b0;
    logic i_rst;
    logic o_scl;
    wire  io_sda;
    logic drv = 1'b0;

    i2c_if h();
    pullup (io_sda);
    assign io_sda = drv ? 1'b0 : 1'bz;

    i2c_master_controller #(.CLK_DIV(CD)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .host   (h),
        .o_scl  (o_scl),
        .io_sda (io_sda)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // bus monitor / slave state
    logic       ps_c = 1'b1, ps_s = 1'b1, mc, ms;
    logic       active = 1'b0, matched = 1'b0, rdmode = 1'b0, nack_sda = 1'b0;
    logic [7:0] ash = '0, wsh = '0, slv_buf = '0;
    int         hi_cnt = 0, rise = 0, start_cnt = 0, stop_cnt = 0, bus_err = 0, last_pulses = -1;

    // model state
    logic [7:0] m_rdata = 8'h00, m_buf = 8'h00;

    initial forever begin
        @(negedge i_clk);
        mc = o_scl;
        ms = (io_sda !== 1'b0);
        if (ps_c && mc && ps_s && !ms) begin
            if (hi_cnt < CD) bus_err++;
            start_cnt++;
            active = 1'b1; rise = 0; matched = 1'b0; rdmode = 1'b0; ash = '0; wsh = '0;
        end else if (ps_c && mc && !ps_s && ms) begin
            if (!active) bus_err++;
            stop_cnt++;
            last_pulses = rise - 1;  // the STOP bit's own SCL rise is not a data/ack pulse
            active = 1'b0; drv = 1'b0;
        end else if (active && !ps_c && mc) begin
            rise++;
            if (rise <= 8) ash = {ash[6:0], ms};
            if (rise == 8) begin
                matched = (ash[7:1] == I2C_DEF_ADDR);
                rdmode  = ash[0];
            end
            if (matched && !rdmode && rise >= 10 && rise <= 17) wsh = {wsh[6:0], ms};
            if (matched && !rdmode && rise == 17) slv_buf = wsh;
            if (matched && rdmode && rise == 18) nack_sda = ms;
        end else if (active && ps_c && !mc) begin
            if (rise == 8 && matched)                          drv = 1'b1;
            else if (rise >= 9 && rise <= 16 && matched && rdmode) drv = !SLV_BYTE[7-(rise-9)];
            else if (rise == 17 && matched && !rdmode)         drv = 1'b1;
            else                                               drv = 1'b0;
        end
        hi_cnt = (mc && ms) ? hi_cnt + 1 : 0;
        ps_c = mc;
        ps_s = ms;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Caller sits just after a negedge with o_busy low; returns on the negedge where o_done is seen.
    task automatic txn(input logic rw, input logic [6:0] a, input logic [7:0] d, input int poke,
                       output int lat);
        h.i_rw = rw; h.i_addr = a; h.i_wdata = d; h.i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        h.i_start = 1'b0; h.i_rw = ~rw; h.i_addr = ~a; h.i_wdata = ~d;
        chk("busy_after_accept", int'(h.o_busy), 1);
        lat = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            h.i_start = (k == poke);
            if (k == poke) h.i_addr = 7'h12;
            if (h.o_done) begin
                lat = k;
                break;
            end
        end
        h.i_start = 1'b0;
    endtask

    task automatic result(input string nm, input logic rw, input logic e_nack, input logic [7:0] e_rd,
                          input logic [7:0] e_buf, input int e_lat, input int lat,
                          input int s0, input int p0);
        chk({nm, ".latency"}, lat, e_lat);
        chk({nm, ".nack"}, int'(h.o_nack), int'(e_nack));
        chk({nm, ".busy_at_done"}, int'(h.o_busy), 0);
        chk({nm, ".rdata"}, int'(h.o_rdata), int'(e_rd));
        chk({nm, ".slave_buf"}, int'(slv_buf), int'(e_buf));
        chk({nm, ".starts"}, start_cnt - s0, 1);
        chk({nm, ".stops"}, stop_cnt - p0, 1);
        chk({nm, ".scl_pulses"}, last_pulses, e_nack ? 9 : 18);
        chk({nm, ".bus_err"}, bus_err, 0);
        if (rw == I2C_RW_READ && !e_nack) chk({nm, ".nack_slot_released"}, int'(nack_sda), 1);
    endtask

    task automatic model(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         output logic e_nack, output int e_lat);
        e_nack = (a != I2C_DEF_ADDR);
        e_lat  = (e_nack ? 11 : 20) * 4 * CD + 1;
        if (!e_nack) begin
            if (rw == I2C_RW_READ) m_rdata = SLV_BYTE;
            else                   m_buf   = d;
        end
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       nack;
        logic [7:0] rdata;
        logic [7:0] sbuf;
        int         lat;
    } vec_t;

    vec_t tab [4];

    initial begin
        int         lat, s0, p0, e_lat;
        logic       e_nack, rw;
        logic [6:0] a;
        logic [7:0] d;

        tab[0] = '{1'b0, 7'h66, 8'hA5, 1'b0, 8'h00, 8'hA5, 321};
        tab[1] = '{1'b1, 7'h66, 8'h00, 1'b0, 8'hAD, 8'hA5, 321};
        tab[2] = '{1'b0, 7'h12, 8'h33, 1'b1, 8'hAD, 8'hA5, 177};
        tab[3] = '{1'b1, 7'h12, 8'h00, 1'b1, 8'hAD, 8'hA5, 177};

        h.i_start = 1'b0; h.i_rw = 1'b0; h.i_addr = '0; h.i_wdata = '0;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("reset.scl", int'(o_scl), 1);
        chk("reset.sda_released", int'(io_sda === 1'b1), 1);
        chk("reset.busy", int'(h.o_busy), 0);
        chk("reset.done", int'(h.o_done), 0);
        chk("reset.nack", int'(h.o_nack), 0);
        chk("reset.rdata", int'(h.o_rdata), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        for (int i = 0; i < 4; i++) begin
            s0 = start_cnt; p0 = stop_cnt;
            txn(tab[i].rw, tab[i].addr, tab[i].wdata, 0, lat);
            result($sformatf("vec%0d", i), tab[i].rw, tab[i].nack, tab[i].rdata, tab[i].sbuf,
                   tab[i].lat, lat, s0, p0);
        end
        m_rdata = tab[3].rdata;
        m_buf   = tab[3].sbuf;

        // i_start with another address while busy must be ignored
        model(I2C_RW_WRITE, 7'h66, 8'h96, e_nack, e_lat);
        s0 = start_cnt; p0 = stop_cnt;
        txn(I2C_RW_WRITE, 7'h66, 8'h96, 100, lat);
        result("ignored_start", I2C_RW_WRITE, e_nack, m_rdata, m_buf, e_lat, lat, s0, p0);

        // asynchronous reset during WRITE bit 3 (bit time 13, quarter 2)
        h.i_rw = I2C_RW_WRITE; h.i_addr = 7'h66; h.i_wdata = 8'h5A; h.i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        h.i_start = 1'b0;
        repeat (13 * 4 * CD + 2 * CD) @(negedge i_clk);
        chk("pre_reset.busy", int'(h.o_busy), 1);
        i_rst = 1'b1;
        #1;
        chk("midrst.scl", int'(o_scl), 1);
        chk("midrst.sda_released", int'(io_sda === 1'b1), 1);
        chk("midrst.busy", int'(h.o_busy), 0);
        chk("midrst.done", int'(h.o_done), 0);
        chk("midrst.nack", int'(h.o_nack), 0);
        chk("midrst.rdata", int'(h.o_rdata), 0);
        m_rdata = 8'h00;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        model(I2C_RW_WRITE, 7'h66, 8'h3C, e_nack, e_lat);
        s0 = start_cnt; p0 = stop_cnt;
        txn(I2C_RW_WRITE, 7'h66, 8'h3C, 0, lat);
        result("after_reset", I2C_RW_WRITE, e_nack, m_rdata, m_buf, e_lat, lat, s0, p0);

        // back-to-back: the read is requested on the cycle right after o_done
        model(I2C_RW_WRITE, 7'h66, 8'hC3, e_nack, e_lat);
        s0 = start_cnt; p0 = stop_cnt;
        txn(I2C_RW_WRITE, 7'h66, 8'hC3, 0, lat);
        result("b2b_write", I2C_RW_WRITE, e_nack, m_rdata, m_buf, e_lat, lat, s0, p0);
        model(I2C_RW_READ, 7'h66, 8'h00, e_nack, e_lat);
        s0 = start_cnt; p0 = stop_cnt;
        txn(I2C_RW_READ, 7'h66, 8'h00, 0, lat);
        result("b2b_read", I2C_RW_READ, e_nack, m_rdata, m_buf, e_lat, lat, s0, p0);

        for (int i = 0; i < 8; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? I2C_DEF_ADDR : 7'($urandom_range(0, 127));
            d  = 8'($urandom_range(0, 255));
            model(rw, a, d, e_nack, e_lat);
            s0 = start_cnt; p0 = stop_cnt;
            txn(rw, a, d, 0, lat);
            result($sformatf("rand%0d", i), rw, e_nack, m_rdata, m_buf, e_lat, lat, s0, p0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
